wishbone_slave: RTL and testbench
=================================

# wishbone_slave

Single-transfer Wishbone responder that bridges a bus master to a simple request/complete backend such as a memory, register file or peripheral core. It decodes one address window, issues a single-cycle backend request, waits for completion, and terminates each bus cycle with exactly one of ack, err or rty. It handles only single READ/WRITE transfers; there are no block or RMW cycles.

## Interface
- TAGSIZE, 2, width of the Wishbone tag signals
- BASE_ADDR, 32'h0000_0000, first byte address of the decoded window
- ADDR_SPAN, 32'h0000_1000, window size in bytes; must be nonzero
- TIMEOUT_CYCLES, 16, backend wait limit; used only with WB_SLAVE_TIMEOUT_EN
- Reset is asynchronous and active-low. One clock.
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- wb_dat_i  in  32  write data from master
- wb_dat_o  out  32  read data to master
- wb_tgd_i / wb_tgd_o  in/out  TAGSIZE  data tags; wb_tgd_o returns the tgc captured at acceptance
- wb_adr_i  in  32  byte address
- wb_tga_i, wb_tgc_i  in  TAGSIZE  address and cycle tags; wb_tga_i is ignored
- wb_cyc_i, wb_stb_i, wb_we_i, wb_lock_i  in  1  cycle, strobe, write enable, lock; wb_lock_i is ignored
- wb_sel_i  in  4  byte selects
- wb_ack_o, wb_err_o, wb_rty_o  out  1  termination signals
- addr_o  out  32  offset, computed as wb_adr_i - BASE_ADDR
- data_o  out  32  backend write data
- we_o  out  4  byte write enables; 0 means read
- valid_o  out  1  one-cycle backend request pulse
- data_i  in  32  backend read data
- valid_i  in  1  backend completion
- busy_i  in  1  backend cannot accept a request

## Operation
- States: IDLE, WAIT, ACK, ERR, RTY, DRAIN. All outputs are registered.
- IDLE, when wb_cyc_i & wb_stb_i is sampled:
  - Address out of window (wb_adr_i < BASE_ADDR, or wb_adr_i-BASE_ADDR >= ADDR_SPAN): go to ERR.
  - Write with wb_sel_i == 0: go to ERR.
  - Otherwise, if busy_i: go to RTY.
  - Otherwise: latch addr_o, data_o, we_o (= wb_we_i ? wb_sel_i : 4'b0) and tgc; pulse valid_o; go to WAIT.
- Decode priority is address error > sel error > busy.
- WAIT:
  - valid_i: capture data_i into wb_dat_o on reads; go to ACK.
  - wb_cyc_i low without valid_i (master abort): go to DRAIN.
  - valid_i and cyc drop in the same cycle: completion wins; go to ACK.
- ACK, ERR, RTY: assert the matching termination for exactly one cycle, then go to IDLE. Terminations are mutually exclusive.
- DRAIN: wait for valid_i, then go to IDLE. No termination is driven.
- valid_i outside WAIT/DRAIN is ignored.
- wb_dat_o holds its last value outside ACK. On writes it is left unchanged.

## Timing
- Reset values: all outputs 0; state IDLE. Reset mid-transfer returns to IDLE at once, with no termination and no valid_o.
- A request is sampled at edge N. valid_o is high during cycle N+1 (first WAIT cycle).
- valid_i may arrive in the same cycle as valid_o. Minimum latency: wb_ack_o high in cycle N+2.
- ERR/RTY path: wb_err_o or wb_rty_o high in cycle N+1. valid_o stays 0.
- After any termination the slave is in IDLE. A still-asserted stb in the cycle after the termination is sampled as a new request.
- Back-to-back throughput: one transfer per 3 cycles minimum.

## Configuration
- WB_SLAVE_TIMEOUT_EN defined:
  - A counter runs in WAIT and resets on entry.
  - If TIMEOUT_CYCLES cycles pass without valid_i, wb_err_o is asserted for one cycle (via ERR) and the state returns to IDLE.
  - A later stray valid_i is ignored.
- Not defined: no counter is built. WAIT is unbounded.

## Test plan
- Read at BASE_ADDR+0x10, valid_i 3 cycles after valid_o with data_i=32'hDEADBEEF -> addr_o=0x10, we_o=0, one valid_o pulse, one-cycle ack, wb_dat_o=32'hDEADBEEF.
- Write 32'h1234_5678 with sel=4'b0011, valid_i in the same cycle as valid_o -> data_o=32'h1234_5678, we_o=4'b0011, ack in cycle N+2.
- Address BASE_ADDR+ADDR_SPAN, or a write with sel=0 -> wb_err_o in cycle N+1 for one cycle, valid_o never asserted.
- busy_i=1 at request -> wb_rty_o in cycle N+1. Retry with busy_i=0 -> normal ack.
- cyc dropped 2 cycles into WAIT, valid_i 4 cycles later -> no ack/err/rty; the next request is accepted after DRAIN exits.
- With WB_SLAVE_TIMEOUT_EN and no valid_i -> wb_err_o after 16 WAIT cycles. rstn_i pulsed mid-WAIT -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/wishbone_slave.sv
// Single-transfer Wishbone responder bridging one address window to a request/complete backend.
// Optional macro WB_SLAVE_TIMEOUT_EN bounds the backend wait with an error termination.
module wishbone_slave #(
  parameter int unsigned TAGSIZE        = 2,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] ADDR_SPAN      = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  input  logic [TAGSIZE-1:0] wb_tgd_i,
  output logic [TAGSIZE-1:0] wb_tgd_o,
  input  logic [31:0]        wb_adr_i,
  input  logic [TAGSIZE-1:0] wb_tga_i,
  input  logic [TAGSIZE-1:0] wb_tgc_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic               wb_lock_i,
  input  logic [3:0]         wb_sel_i,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic [31:0]        addr_o,
  output logic [31:0]        data_o,
  output logic [3:0]         we_o,
  output logic               valid_o,
  input  logic [31:0]        data_i,
  input  logic               valid_i,
  input  logic               busy_i
);

  typedef enum logic [2:0] {StIdle, StWait, StAck, StErr, StRty, StDrain} state_e;

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d, data_q, data_d, rdat_q, rdat_d;
  logic [3:0]          we_q, we_d;
  logic [TAGSIZE-1:0]  tgd_q, tgd_d;
  logic                valid_q, valid_d;
  logic                ack_q, err_q, rty_q;
  logic [31:0]         offset;
  logic                req, addr_err, sel_err, timeout;
  logic                unused;

  assign unused   = ^{wb_tgd_i, wb_tga_i, wb_lock_i};
  assign offset   = wb_adr_i - BASE_ADDR;
  assign req      = wb_cyc_i & wb_stb_i;
  assign addr_err = (wb_adr_i < BASE_ADDR) || (offset >= ADDR_SPAN);
  assign sel_err  = wb_we_i && (wb_sel_i == 4'b0000);

`ifdef WB_SLAVE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  // Held at zero outside WAIT so every WAIT entry starts a fresh count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (state_q != StWait) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    tgd_d   = tgd_q;
    rdat_d  = rdat_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (addr_err || sel_err) begin
            state_d = StErr;
          end else if (busy_i) begin
            state_d = StRty;
          end else begin
            addr_d  = offset;
            data_d  = wb_dat_i;
            we_d    = wb_we_i ? wb_sel_i : 4'b0000;
            tgd_d   = wb_tgc_i;
            valid_d = 1'b1;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Completion beats a simultaneous abort or timeout.
        if (valid_i) begin
          if (we_q == 4'b0000) rdat_d = data_i;
          state_d = StAck;
        end else if (!wb_cyc_i) begin
          state_d = StDrain;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StAck, StErr, StRty: state_d = StIdle;
      StDrain: begin
        if (valid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= '0;
      tgd_q   <= '0;
      rdat_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      tgd_q   <= tgd_d;
      rdat_q  <= rdat_d;
      valid_q <= valid_d;
      ack_q   <= (state_d == StAck);
      err_q   <= (state_d == StErr);
      rty_q   <= (state_d == StRty);
    end
  end

  assign wb_dat_o = rdat_q;
  assign wb_tgd_o = tgd_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = rty_q;
  assign addr_o   = addr_q;
  assign data_o   = data_q;
  assign we_o     = we_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_wishbone_slave.sv
// Directed self-checking bench for wishbone_slave; window 0x2000..0x2FFF.
module tb_wishbone_slave;

  localparam logic [31:0] Base = 32'h0000_2000;
  localparam logic [31:0] Span = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [31:0] wb_dat_i, wb_dat_o, wb_adr_i, addr_o, data_o, data_i;
  logic [1:0]  wb_tgd_i, wb_tgd_o, wb_tga_i, wb_tgc_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_lock_i;
  logic [3:0]  wb_sel_i, we_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o, valid_o, valid_i, busy_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wishbone_slave #(
    .TAGSIZE       (2),
    .BASE_ADDR     (Base),
    .ADDR_SPAN     (Span),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_tgd_i (wb_tgd_i),
    .wb_tgd_o (wb_tgd_o),
    .wb_adr_i (wb_adr_i),
    .wb_tga_i (wb_tga_i),
    .wb_tgc_i (wb_tgc_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_lock_i(wb_lock_i),
    .wb_sel_i (wb_sel_i),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .wb_rty_o (wb_rty_o),
    .addr_o   (addr_o),
    .data_o   (data_o),
    .we_o     (we_o),
    .valid_o  (valid_o),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .busy_i   (busy_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                     input logic [31:0] dat, input logic [1:0] tgc);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_dat_i = dat;
    wb_tgc_i = tgc;
  endtask

  task automatic drop();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
  endtask

  function automatic logic [31:0] terms();
    return {29'd0, wb_ack_o, wb_err_o, wb_rty_o};
  endfunction

  initial begin
    rstn_i = 1'b0;
    wb_dat_i = '0; wb_adr_i = '0; data_i = '0;
    wb_tgd_i = 2'b11; wb_tga_i = 2'b11; wb_tgc_i = '0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_lock_i = 1'b1;
    wb_sel_i = '0; valid_i = 1'b0; busy_i = 1'b0;
    #12;
    check("rst_terms", terms(), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();

    // Read, completion three cycles after the request pulse.
    req(Base + 32'h10, 1'b0, 4'hF, 32'h0, 2'b10);
    tick();
    check("rd_valid", 32'(valid_o), 32'd1);
    check("rd_addr", addr_o, 32'h10);
    check("rd_we", 32'(we_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rd_wait_valid", 32'(valid_o), 32'd0);
      check("rd_wait_terms", terms(), 32'd0);
    end
    tick();
    valid_i = 1'b1;
    data_i  = 32'hDEAD_BEEF;
    tick();
    check("rd_ack", terms(), 32'b100);
    check("rd_dat", wb_dat_o, 32'hDEAD_BEEF);
    check("rd_tgd", 32'(wb_tgd_o), 32'd2);
    valid_i = 1'b0;
    drop();
    tick();
    check("rd_ack_1cyc", terms(), 32'd0);
    check("rd_dat_hold", wb_dat_o, 32'hDEAD_BEEF);

    // Write, completion in the same cycle as the request pulse.
    req(Base + 32'h20, 1'b1, 4'b0011, 32'h1234_5678, 2'b01);
    tick();
    check("wr_valid", 32'(valid_o), 32'd1);
    check("wr_data", data_o, 32'h1234_5678);
    check("wr_we", 32'(we_o), 32'b0011);
    check("wr_addr", addr_o, 32'h20);
    valid_i = 1'b1;
    data_i  = 32'hFFFF_FFFF;
    tick();
    check("wr_ack_n2", terms(), 32'b100);
    check("wr_dat_keep", wb_dat_o, 32'hDEAD_BEEF);
    check("wr_tgd", 32'(wb_tgd_o), 32'd1);
    valid_i = 1'b0;
    drop();
    tick();
    check("wr_ack_1cyc", terms(), 32'd0);

    // Error paths: above window, below window, write with no selects, address error over busy.
    req(Base + Span, 1'b0, 4'hF, 32'h0, 2'b00);
    tick();
    check("err_hi", terms(), 32'b010);
    check("err_hi_valid", 32'(valid_o), 32'd0);
    drop();
    tick();
    check("err_1cyc", terms(), 32'd0);
    req(Base - 32'h4, 1'b0, 4'hF, 32'h0, 2'b00);
    tick();
    check("err_lo", terms(), 32'b010);
    drop();
    tick();
    req(Base + Span - 32'h4, 1'b1, 4'b0000, 32'h0, 2'b00);
    tick();
    check("err_sel0", terms(), 32'b010);
    check("err_sel0_valid", 32'(valid_o), 32'd0);
    drop();
    tick();
    busy_i = 1'b1;
    req(Base + Span, 1'b0, 4'hF, 32'h0, 2'b00);
    tick();
    check("err_over_busy", terms(), 32'b010);
    drop();
    tick();

    // Busy gives retry; master keeps strobing and is accepted once busy clears.
    req(Base + Span - 32'h4, 1'b0, 4'hF, 32'h0, 2'b11);
    tick();
    check("rty", terms(), 32'b001);
    check("rty_valid", 32'(valid_o), 32'd0);
    busy_i = 1'b0;
    tick();
    check("rty_1cyc", terms(), 32'd0);
    tick();
    check("retry_valid", 32'(valid_o), 32'd1);
    check("retry_addr", addr_o, 32'hFFC);
    valid_i = 1'b1;
    data_i  = 32'hA5A5_0001;
    tick();
    check("retry_ack", terms(), 32'b100);
    check("retry_dat", wb_dat_o, 32'hA5A5_0001);
    valid_i = 1'b0;
    drop();
    tick();

    // Master abort two cycles into WAIT; completion arrives four cycles later.
    req(Base + 32'h30, 1'b0, 4'hF, 32'h0, 2'b00);
    tick();
    tick();
    drop();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_terms", terms(), 32'd0);
    end
    valid_i = 1'b1;
    data_i  = 32'h5555_AAAA;
    req(Base + 32'h40, 1'b0, 4'hF, 32'h0, 2'b00);
    tick();
    check("drain_exit_terms", terms(), 32'd0);
    check("drain_exit_valid", 32'(valid_o), 32'd0);
    check("drain_dat", wb_dat_o, 32'hA5A5_0001);
    valid_i = 1'b0;
    tick();
    check("post_drain_valid", 32'(valid_o), 32'd1);
    check("post_drain_addr", addr_o, 32'h40);
    valid_i = 1'b1;
    data_i  = 32'h0BAD_F00D;
    tick();
    check("post_drain_ack", terms(), 32'b100);
    check("post_drain_dat", wb_dat_o, 32'h0BAD_F00D);
    valid_i = 1'b0;
    drop();
    tick();

    // Long backend wait: bounded only when the timeout is built in.
    req(Base + 32'h50, 1'b0, 4'hF, 32'h0, 2'b00);
    tick();
    check("long_n1", terms(), 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("long_wait", terms(), 32'd0);
    end
    tick();
`ifdef WB_SLAVE_TIMEOUT_EN
    check("timeout_err", terms(), 32'b010);
    drop();
    tick();
    check("timeout_1cyc", terms(), 32'd0);
    valid_i = 1'b1;
    tick();
    check("timeout_stray", terms(), 32'd0);
    valid_i = 1'b0;
`else
    check("no_timeout", terms(), 32'd0);
    valid_i = 1'b1;
    data_i  = 32'h7777_0000;
    tick();
    check("late_ack", terms(), 32'b100);
    check("late_dat", wb_dat_o, 32'h7777_0000);
    valid_i = 1'b0;
    drop();
`endif
    tick();

    // Asynchronous reset in the middle of WAIT.
    req(Base + 32'h60, 1'b1, 4'hF, 32'hCAFE_0000, 2'b11);
    tick();
    tick();
    rstn_i = 1'b0;
    #1;
    check("mid_rst_terms", terms(), 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_data", data_o, 32'd0);
    check("mid_rst_we", 32'(we_o), 32'd0);
    check("mid_rst_dat", wb_dat_o, 32'd0);
    check("mid_rst_tgd", 32'(wb_tgd_o), 32'd0);
    drop();
    rstn_i = 1'b1;
    valid_i = 1'b1;
    tick();
    check("post_rst_terms", terms(), 32'd0);
    check("post_rst_valid", 32'(valid_o), 32'd0);
    valid_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
